// File: rtl/pck_enc.sv
`default_nettype none
// ============================================================================
// Module   : pck_enc
// Brief    : Shared RV32I encoder types, opcode/funct constants and helpers.
// Revision : 1.0 - initial release
// ============================================================================
package pck_enc;

    typedef enum logic [5:0] {
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI,
        SLLI, SRLI, SRAI,
        LB, LH, LW, LBU, LHU,
        JALR,
        SB, SH, SW,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LUI, AUIPC, JAL,
        FENCE, FENCE_I, ECALL, EBREAK
    } op_e;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SYS
    } fmt_e;

    localparam logic [6:0] c_OPC_LUI      = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL      = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR     = 7'b1100111;
    localparam logic [6:0] c_OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] c_OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE    = 7'b0100011;
    localparam logic [6:0] c_OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] c_OPC_OP       = 7'b0110011;
    localparam logic [6:0] c_OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] c_OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] c_F3_ADD_SUB = 3'b000;
    localparam logic [2:0] c_F3_SLL     = 3'b001;
    localparam logic [2:0] c_F3_SLT     = 3'b010;
    localparam logic [2:0] c_F3_SLTU    = 3'b011;
    localparam logic [2:0] c_F3_XOR     = 3'b100;
    localparam logic [2:0] c_F3_SRL_SRA = 3'b101;
    localparam logic [2:0] c_F3_OR      = 3'b110;
    localparam logic [2:0] c_F3_AND     = 3'b111;

    localparam logic [2:0] c_F3_BEQ  = 3'b000;
    localparam logic [2:0] c_F3_BNE  = 3'b001;
    localparam logic [2:0] c_F3_BLT  = 3'b100;
    localparam logic [2:0] c_F3_BGE  = 3'b101;
    localparam logic [2:0] c_F3_BLTU = 3'b110;
    localparam logic [2:0] c_F3_BGEU = 3'b111;

    localparam logic [2:0] c_F3_BYTE  = 3'b000;
    localparam logic [2:0] c_F3_HALF  = 3'b001;
    localparam logic [2:0] c_F3_WORD  = 3'b010;
    localparam logic [2:0] c_F3_BYTEU = 3'b100;
    localparam logic [2:0] c_F3_HALFU = 3'b101;

    localparam logic [2:0] c_F3_JALR    = 3'b000;
    localparam logic [2:0] c_F3_FENCE   = 3'b000;
    localparam logic [2:0] c_F3_FENCE_I = 3'b001;
    localparam logic [2:0] c_F3_PRIV    = 3'b000;

    localparam logic [6:0] c_F7_BASE = 7'b0000000;
    localparam logic [6:0] c_F7_ALT  = 7'b0100000;

    localparam logic [11:0] c_IMM_ECALL  = 12'h000;
    localparam logic [11:0] c_IMM_EBREAK = 12'h001;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    // Sign-extension checks: the value fits when all bits above the field's
    // sign bit replicate it.
    function automatic logic fits_s12(input logic [31:0] v);
        return v[31:11] == {21{v[11]}};
    endfunction

    function automatic logic fits_s13(input logic [31:0] v);
        return v[31:12] == {20{v[12]}};
    endfunction

    function automatic logic fits_s21(input logic [31:0] v);
        return v[31:20] == {12{v[20]}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv32i_enc_comb.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_enc_comb
// Brief    : Combinational RV32I encoder with immediate legality check.
//            FENCE/FENCE_I/ECALL/EBREAK require RV32I_ENCODER_SYSTEM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rv32i_enc_comb
    import pck_enc::*;
(
    input  op_e         i_op,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [31:0] i_imm,
    output logic [31:0] o_instr,
    output logic        o_err
);

    fmt_e        w_fmt;
    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [11:0] w_sys_imm;
    logic        w_legal_op;
    logic        w_imm_ok;
    logic [31:0] w_word;

    always_comb begin
        w_fmt      = FMT_R;
        w_opc      = c_OPC_OP;
        w_f3       = c_F3_ADD_SUB;
        w_f7       = c_F7_BASE;
        w_sys_imm  = 12'h000;
        w_legal_op = 1'b1;
        case (i_op)
            ADD:   begin w_f3 = c_F3_ADD_SUB; end
            SUB:   begin w_f3 = c_F3_ADD_SUB; w_f7 = c_F7_ALT; end
            SLL:   begin w_f3 = c_F3_SLL;  end
            SLT:   begin w_f3 = c_F3_SLT;  end
            SLTU:  begin w_f3 = c_F3_SLTU; end
            XOR:   begin w_f3 = c_F3_XOR;  end
            SRL:   begin w_f3 = c_F3_SRL_SRA; end
            SRA:   begin w_f3 = c_F3_SRL_SRA; w_f7 = c_F7_ALT; end
            OR:    begin w_f3 = c_F3_OR;   end
            AND:   begin w_f3 = c_F3_AND;  end
            ADDI:  begin w_fmt = FMT_I; w_opc = c_OPC_OP_IMM; w_f3 = c_F3_ADD_SUB; end
            SLTI:  begin w_fmt = FMT_I; w_opc = c_OPC_OP_IMM; w_f3 = c_F3_SLT;  end
            SLTIU: begin w_fmt = FMT_I; w_opc = c_OPC_OP_IMM; w_f3 = c_F3_SLTU; end
            XORI:  begin w_fmt = FMT_I; w_opc = c_OPC_OP_IMM; w_f3 = c_F3_XOR;  end
            ORI:   begin w_fmt = FMT_I; w_opc = c_OPC_OP_IMM; w_f3 = c_F3_OR;   end
            ANDI:  begin w_fmt = FMT_I; w_opc = c_OPC_OP_IMM; w_f3 = c_F3_AND;  end
            SLLI:  begin w_fmt = FMT_SH; w_opc = c_OPC_OP_IMM; w_f3 = c_F3_SLL; end
            SRLI:  begin w_fmt = FMT_SH; w_opc = c_OPC_OP_IMM; w_f3 = c_F3_SRL_SRA; end
            SRAI:  begin
                w_fmt = FMT_SH; w_opc = c_OPC_OP_IMM; w_f3 = c_F3_SRL_SRA; w_f7 = c_F7_ALT;
            end
            LB:    begin w_fmt = FMT_I; w_opc = c_OPC_LOAD; w_f3 = c_F3_BYTE;  end
            LH:    begin w_fmt = FMT_I; w_opc = c_OPC_LOAD; w_f3 = c_F3_HALF;  end
            LW:    begin w_fmt = FMT_I; w_opc = c_OPC_LOAD; w_f3 = c_F3_WORD;  end
            LBU:   begin w_fmt = FMT_I; w_opc = c_OPC_LOAD; w_f3 = c_F3_BYTEU; end
            LHU:   begin w_fmt = FMT_I; w_opc = c_OPC_LOAD; w_f3 = c_F3_HALFU; end
            JALR:  begin w_fmt = FMT_I; w_opc = c_OPC_JALR; w_f3 = c_F3_JALR;  end
            SB:    begin w_fmt = FMT_S; w_opc = c_OPC_STORE; w_f3 = c_F3_BYTE; end
            SH:    begin w_fmt = FMT_S; w_opc = c_OPC_STORE; w_f3 = c_F3_HALF; end
            SW:    begin w_fmt = FMT_S; w_opc = c_OPC_STORE; w_f3 = c_F3_WORD; end
            BEQ:   begin w_fmt = FMT_B; w_opc = c_OPC_BRANCH; w_f3 = c_F3_BEQ;  end
            BNE:   begin w_fmt = FMT_B; w_opc = c_OPC_BRANCH; w_f3 = c_F3_BNE;  end
            BLT:   begin w_fmt = FMT_B; w_opc = c_OPC_BRANCH; w_f3 = c_F3_BLT;  end
            BGE:   begin w_fmt = FMT_B; w_opc = c_OPC_BRANCH; w_f3 = c_F3_BGE;  end
            BLTU:  begin w_fmt = FMT_B; w_opc = c_OPC_BRANCH; w_f3 = c_F3_BLTU; end
            BGEU:  begin w_fmt = FMT_B; w_opc = c_OPC_BRANCH; w_f3 = c_F3_BGEU; end
            LUI:   begin w_fmt = FMT_U; w_opc = c_OPC_LUI;   end
            AUIPC: begin w_fmt = FMT_U; w_opc = c_OPC_AUIPC; end
            JAL:   begin w_fmt = FMT_J; w_opc = c_OPC_JAL;   end
`ifdef RV32I_ENCODER_SYSTEM_EN
            // FENCE carries pred/succ from imm[7:4]/imm[3:0]; fm, rd, rs1 are zero.
            FENCE: begin
                w_fmt = FMT_SYS; w_opc = c_OPC_MISC_MEM; w_f3 = c_F3_FENCE;
                w_sys_imm = {4'b0000, i_imm[7:0]};
            end
            FENCE_I: begin w_fmt = FMT_SYS; w_opc = c_OPC_MISC_MEM; w_f3 = c_F3_FENCE_I; end
            ECALL: begin
                w_fmt = FMT_SYS; w_opc = c_OPC_SYSTEM; w_f3 = c_F3_PRIV; w_sys_imm = c_IMM_ECALL;
            end
            EBREAK: begin
                w_fmt = FMT_SYS; w_opc = c_OPC_SYSTEM; w_f3 = c_F3_PRIV; w_sys_imm = c_IMM_EBREAK;
            end
`else
            FENCE, FENCE_I, ECALL, EBREAK: w_legal_op = 1'b0;
`endif
            default: w_legal_op = 1'b0;
        endcase
    end

    always_comb begin
        w_word   = c_NOP;
        w_imm_ok = 1'b1;
        case (w_fmt)
            FMT_R: w_word = {w_f7, i_rs2, i_rs1, w_f3, i_rd, w_opc};
            FMT_I: begin
                w_imm_ok = fits_s12(i_imm);
                w_word   = {i_imm[11:0], i_rs1, w_f3, i_rd, w_opc};
            end
            FMT_SH: begin
                w_imm_ok = (i_imm[31:5] == 27'd0);
                w_word   = {w_f7, i_imm[4:0], i_rs1, w_f3, i_rd, w_opc};
            end
            FMT_S: begin
                w_imm_ok = fits_s12(i_imm);
                w_word   = {i_imm[11:5], i_rs2, i_rs1, w_f3, i_imm[4:0], w_opc};
            end
            FMT_B: begin
                w_imm_ok = !i_imm[0] && fits_s13(i_imm);
                w_word   = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, w_f3,
                            i_imm[4:1], i_imm[11], w_opc};
            end
            FMT_U: begin
                w_imm_ok = (i_imm[11:0] == 12'd0);
                w_word   = {i_imm[31:12], i_rd, w_opc};
            end
            FMT_J: begin
                w_imm_ok = !i_imm[0] && fits_s21(i_imm);
                w_word   = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, w_opc};
            end
            FMT_SYS: w_word = {w_sys_imm, 5'd0, w_f3, 5'd0, w_opc};
            default: w_word = c_NOP;
        endcase
    end

    assign o_err   = !w_legal_op || !w_imm_ok;
    assign o_instr = o_err ? c_NOP : w_word;

endmodule
`default_nettype wire

// File: rtl/rv32i_encoder.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_encoder
// Brief    : RV32I instruction encoder with a 2-entry output skid FIFO and an
//            accepted-request counter. System ops gated by RV32I_ENCODER_SYSTEM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rv32i_encoder
    import pck_enc::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  op_e         i_op,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [31:0] i_imm,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_instr,
    output logic        o_err,
    output logic [15:0] o_count
);

    logic [31:0] w_enc_instr;
    logic        w_enc_err;
    logic        w_push;
    logic        w_pop;

    logic [1:0][31:0] instr_q, instr_d;
    logic [1:0]       err_q,   err_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       fill_q,  fill_d;
    logic [15:0]      count_q, count_d;
    logic             live_q,  live_d;

    rv32i_enc_comb u_enc (
        .i_op    (i_op),
        .i_rd    (i_rd),
        .i_rs1   (i_rs1),
        .i_rs2   (i_rs2),
        .i_imm   (i_imm),
        .o_instr (w_enc_instr),
        .o_err   (w_enc_err)
    );

    // live_q holds o_ready low for the cycle in which reset is sampled.
    assign o_valid = (fill_q != 2'd0);
    assign o_ready = live_q && (fill_q != 2'd2);
    assign w_push  = i_valid && o_ready;
    assign w_pop   = o_valid && i_ready;

    always_comb begin
        instr_d  = instr_q;
        err_d    = err_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        count_d  = count_q;
        live_d   = 1'b1;
        if (w_push) begin
            instr_d[wr_ptr_q] = w_enc_instr;
            err_d[wr_ptr_q]   = w_enc_err;
            wr_ptr_d          = !wr_ptr_q;
            count_d           = count_q + 16'd1;
        end
        if (w_pop) begin
            rd_ptr_d = !rd_ptr_q;
        end
        case ({w_push, w_pop})
            2'b10:   fill_d = fill_q + 2'd1;
            2'b01:   fill_d = fill_q - 2'd1;
            default: fill_d = fill_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            instr_q  <= {c_NOP, c_NOP};
            err_q    <= 2'b00;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            fill_q   <= 2'd0;
            count_q  <= 16'd0;
            live_q   <= 1'b0;
        end else begin
            instr_q  <= instr_d;
            err_q    <= err_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            count_q  <= count_d;
            live_q   <= live_d;
        end
    end

    assign o_instr = instr_q[rd_ptr_q];
    assign o_err   = err_q[rd_ptr_q];
    assign o_count = count_q;

endmodule
`default_nettype wire
